// File: rtl/alu_access_arbiter_if.sv
// alu_access_arbiter_if
// Groups the two request channels, the response channel and the ALU drive
// signals of the ALU access arbiter.
//   master : the environment (requesters, response consumer, the ALU itself)
//   slave  : the arbiter
interface alu_access_arbiter_if;
  // Requester 0
  logic        Req0Valid;
  logic        Req0Ready;
  logic [15:0] Req0A;
  logic [15:0] Req0B;
  logic [4:0]  Req0FunSel;
  logic        Req0WF;
  // Requester 1
  logic        Req1Valid;
  logic        Req1Ready;
  logic [15:0] Req1A;
  logic [15:0] Req1B;
  logic [4:0]  Req1FunSel;
  logic        Req1WF;
  // Response channel
  logic        RspValid;
  logic        RspReady;
  logic        RspId;
  logic [15:0] RspResult;
  logic [3:0]  RspFlags;
  // ALU ports
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [15:0] AluOut;
  logic [3:0]  AluFlags;

  modport master (
    output Req0Valid, Req0A, Req0B, Req0FunSel, Req0WF,
    input  Req0Ready,
    output Req1Valid, Req1A, Req1B, Req1FunSel, Req1WF,
    input  Req1Ready,
    input  RspValid, RspId, RspResult, RspFlags,
    output RspReady,
    input  AluA, AluB, AluFunSel, AluWF,
    output AluOut, AluFlags
  );

  modport slave (
    input  Req0Valid, Req0A, Req0B, Req0FunSel, Req0WF,
    output Req0Ready,
    input  Req1Valid, Req1A, Req1B, Req1FunSel, Req1WF,
    output Req1Ready,
    output RspValid, RspId, RspResult, RspFlags,
    input  RspReady,
    output AluA, AluB, AluFunSel, AluWF,
    input  AluOut, AluFlags
  );
endinterface

// File: rtl/alu_access_arbiter.sv
// alu_access_arbiter
// Shares one registered ALU between two requesters. One operation at a time:
// IDLE (grant/accept) -> EXEC (ALU driven, flags may be written) -> WAIT
// (ALU result settles, captured) -> RESP (held until the consumer takes it).
// Outside EXEC the ALU sees a harmless pattern with WF low, so the ALU flags
// advance exactly once per accepted operation.
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN  defined   -> round-robin between the requesters
//                           undefined -> fixed priority, requester 0 first
`default_nettype none

module alu_access_arbiter (
  input  logic                 Clock,
  input  logic                 Reset,
  alu_access_arbiter_if.slave  bus
);

  localparam int DATA_W = 16;
  localparam int FS_W   = 5;
  localparam int FLAG_W = 4;

  // Pass-A, 16-bit: harmless with WF low
  localparam logic [FS_W-1:0] SAFE_FUNSEL = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q;

  // ALU drive registers; they also act as the latched operation
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [FS_W-1:0]     alu_fs_q;
  logic                alu_wf_q;
  logic                id_q;

  // Response registers
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic [FLAG_W-1:0]   rsp_flags_q;

  // Arbitration
  logic                grant0;
  logic                grant1;
  logic                accept;

  // Operation of the granted requester
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [FS_W-1:0]     sel_fs;
  logic                sel_wf;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Last requester granted; reset to 1 so requester 0 is favoured first
  logic                last_grant_q;
`endif

  // Grant at most one requester, only in IDLE and never while reset is applied
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && !Reset) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (bus.Req0Valid && bus.Req1Valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = bus.Req0Valid;
        grant1 = bus.Req1Valid;
      end
`else
      grant0 = bus.Req0Valid;
      grant1 = bus.Req1Valid && !bus.Req0Valid;
`endif
    end
  end

  assign accept        = grant0 | grant1;
  assign bus.Req0Ready = grant0;
  assign bus.Req1Ready = grant1;

  // Select the operation fields of whichever requester is granted
  always_comb begin
    sel_a  = bus.Req0A;
    sel_b  = bus.Req0B;
    sel_fs = bus.Req0FunSel;
    sel_wf = bus.Req0WF;
    if (grant1) begin
      sel_a  = bus.Req1A;
      sel_b  = bus.Req1B;
      sel_fs = bus.Req1FunSel;
      sel_wf = bus.Req1WF;
    end
  end

  // Operation sequencer: accept, drive ALU for one clock, capture, respond
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fs_q     <= SAFE_FUNSEL;
      alu_wf_q     <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            alu_fs_q <= sel_fs;
            alu_wf_q <= sel_wf;
            id_q     <= grant1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          // ALU executes at this edge; return it to the safe pattern
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_fs_q <= SAFE_FUNSEL;
          alu_wf_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          // ALU outputs now hold this operation's result
          rsp_result_q <= bus.AluOut;
          rsp_flags_q  <= bus.AluFlags;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.RspReady) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Remember who was granted last so the other one wins a tie next time
  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant1;
    end
  end
`endif

  assign bus.AluA      = alu_a_q;
  assign bus.AluB      = alu_b_q;
  assign bus.AluFunSel = alu_fs_q;
  assign bus.AluWF     = alu_wf_q;

  assign bus.RspValid  = rsp_valid_q;
  assign bus.RspId     = rsp_id_q;
  assign bus.RspResult = rsp_result_q;
  assign bus.RspFlags  = rsp_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_access_arbiter.sv
// tb_alu_access_arbiter
// Bench for alu_access_arbiter with a small registered ALU stand-in.
// Honours ALU_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_alu_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_access_arbiter_if bus ();

  alu_access_arbiter dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: ALU flags as they should be, and last requester granted
  logic [3:0] model_flags = 4'b0000;
  logic       rr_last     = 1'b1;

  // ALU behaviour for the function codes the bench uses. Flags {Z,C,N,O}.
  function automatic logic [19:0] alu_calc(input logic [4:0] fs, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic [15:0] r;
    logic z, c, n, o;
    {z, c, n, o} = f;
    s = '0;
    r = a;
    case (fs)
      5'b00000: begin
        r = {8'h00, a[7:0]};
        z = (r == 16'h0000);
        n = r[7];
      end
      5'b10100, 5'b10101: begin
        s = {1'b0, a} + {1'b0, b} + ((fs == 5'b10101) ? {16'h0000, f[2]} : 17'h0);
        r = s[15:0];
        z = (r == 16'h0000);
        c = s[16];
        n = r[15];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      default: begin
        r = a;
        z = (r == 16'h0000);
        n = r[15];
      end
    endcase
    return {r, z, c, n, o};
  endfunction

  // Registered ALU stand-in: clocks every cycle, flags only when WF is high
  logic [15:0] alu_out_q   = 16'h0000;
  logic [3:0]  alu_flags_q = 4'b0000;
  logic [19:0] alu_next;
  assign alu_next     = alu_calc(bus.AluFunSel, bus.AluA, bus.AluB, alu_flags_q);
  assign bus.AluOut   = alu_out_q;
  assign bus.AluFlags = alu_flags_q;

  always @(posedge clk) begin
    alu_out_q <= alu_next[19:4];
    if (bus.AluWF) alu_flags_q <= alu_next[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] fs, input logic wf);
    if (id == 0) begin
      bus.Req0Valid = v; bus.Req0A = a; bus.Req0B = b; bus.Req0FunSel = fs; bus.Req0WF = wf;
    end else begin
      bus.Req1Valid = v; bus.Req1A = a; bus.Req1B = b; bus.Req1FunSel = fs; bus.Req1WF = wf;
    end
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? bus.Req0Ready : bus.Req1Ready;
  endfunction

  // One complete operation from one requester, with 'hold' cycles of backpressure
  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] fs, input logic wf, input int hold, input string tag,
                        output logic [15:0] obs_r, output logic [3:0] obs_f);
    logic [19:0] t;
    logic [15:0] exp_r;
    logic [3:0]  exp_f;
    int cnt;
    @(negedge clk);
    set_req(id, 1'b1, a, b, fs, wf);
    #1;
    cnt = 0;
    while (!ready_of(id) && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    chk({tag, ".ready"}, 32'(ready_of(id)), 32'd1);
    chk({tag, ".other_ready"}, 32'(ready_of(1 - id)), 32'd0);
    @(posedge clk);
    rr_last = (id != 0);
    t = alu_calc(fs, a, b, model_flags);
    exp_r = t[19:4];
    if (wf) model_flags = t[3:0];
    exp_f = model_flags;
    @(negedge clk);
    set_req(id, 1'b0, 16'h0000, 16'h0000, 5'b00000, 1'b0);
    #1;
    chk({tag, ".exec_a"}, 32'(bus.AluA), 32'(a));
    chk({tag, ".exec_b"}, 32'(bus.AluB), 32'(b));
    chk({tag, ".exec_fs"}, 32'(bus.AluFunSel), 32'(fs));
    chk({tag, ".exec_wf"}, 32'(bus.AluWF), 32'(wf));
    chk({tag, ".exec_rspv"}, 32'(bus.RspValid), 32'd0);
    @(negedge clk); #1;
    chk({tag, ".wait_wf"}, 32'(bus.AluWF), 32'd0);
    chk({tag, ".wait_safe"}, {11'd0, bus.AluFunSel, bus.AluA}, {11'd0, 5'b10000, 16'h0000});
    chk({tag, ".wait_rspv"}, 32'(bus.RspValid), 32'd0);
    @(negedge clk); #1;
    chk({tag, ".resp_v"}, 32'(bus.RspValid), 32'd1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.Req0Valid = 1'b1;
      bus.Req1Valid = 1'b1;
      #1;
      chk({tag, ".hold_v"}, 32'(bus.RspValid), 32'd1);
      chk({tag, ".hold_res"}, 32'(bus.RspResult), 32'(exp_r));
      chk({tag, ".hold_flg"}, 32'(bus.RspFlags), 32'(exp_f));
      chk({tag, ".hold_rdy"}, {30'd0, bus.Req1Ready, bus.Req0Ready}, 32'd0);
      chk({tag, ".hold_wf"}, 32'(bus.AluWF), 32'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.Req0Valid = 1'b0;
      bus.Req1Valid = 1'b0;
    end
    bus.RspReady = 1'b1;
    #1;
    chk({tag, ".rsp_v"}, 32'(bus.RspValid), 32'd1);
    chk({tag, ".rsp_id"}, 32'(bus.RspId), 32'(id));
    chk({tag, ".rsp_res"}, 32'(bus.RspResult), 32'(exp_r));
    chk({tag, ".rsp_flg"}, 32'(bus.RspFlags), 32'(exp_f));
    obs_r = bus.RspResult;
    obs_f = bus.RspFlags;
    @(posedge clk);
    @(negedge clk);
    bus.RspReady = 1'b0;
    #1;
    chk({tag, ".done_v"}, 32'(bus.RspValid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_last = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    logic        exp_id;
    logic [15:0] exp_r;
    logic [19:0] t;
    logic [4:0]  fs_tab [4];
    int cnt;
    fs_tab[0] = 5'b10000; fs_tab[1] = 5'b00000; fs_tab[2] = 5'b10100; fs_tab[3] = 5'b10101;

    set_req(0, 1'b1, 16'h0000, 16'h0000, 5'b00000, 1'b0);
    set_req(1, 1'b1, 16'h0000, 16'h0000, 5'b00000, 1'b0);
    bus.RspReady = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.rdy0", 32'(bus.Req0Ready), 32'd0);
    chk("rst.rdy1", 32'(bus.Req1Ready), 32'd0);
    chk("rst.rspv", 32'(bus.RspValid), 32'd0);
    chk("rst.rspid", 32'(bus.RspId), 32'd0);
    chk("rst.rspres", 32'(bus.RspResult), 32'd0);
    chk("rst.rspflg", 32'(bus.RspFlags), 32'd0);
    chk("rst.alua", 32'(bus.AluA), 32'd0);
    chk("rst.alub", 32'(bus.AluB), 32'd0);
    chk("rst.alufs", 32'(bus.AluFunSel), 32'h10);
    chk("rst.aluwf", 32'(bus.AluWF), 32'd0);
    rst = 1'b0;
    bus.Req0Valid = 1'b0;
    bus.Req1Valid = 1'b0;

    // Directed operations
    run_op(0, 16'h7FFF, 16'h0001, 5'b10100, 1'b1, 0, "add_ovf", r, f);
    chk("tp.add_res", 32'(r), 32'h8000);
    chk("tp.add_flg", 32'(f), 32'h3);
    run_op(1, 16'h12F0, 16'h0000, 5'b00000, 1'b1, 0, "pass8", r, f);
    chk("tp.pass8_res", 32'(r), 32'h00F0);
    chk("tp.pass8_n", 32'(f[1]), 32'd1);
    run_op(0, 16'h1234, 16'h1111, 5'b10100, 1'b1, 5, "hold5", r, f);
    run_op(1, 16'hFFFF, 16'h0001, 5'b10100, 1'b1, 0, "carry", r, f);
    chk("tp.carry_flg", 32'(f), 32'hC);
    run_op(0, 16'h0001, 16'h0002, 5'b10101, 1'b1, 1, "adc", r, f);
    chk("tp.adc_res", 32'(r), 32'h0004);
    run_op(1, 16'h8000, 16'h8000, 5'b10100, 1'b0, 0, "nowf", r, f);

    // Randomized operations against the reference model
    for (int i = 0; i < 12; i++) begin
      run_op($urandom_range(0, 1), 16'($urandom), 16'($urandom), fs_tab[$urandom_range(0, 3)],
             1'($urandom_range(0, 1)), $urandom_range(0, 2), $sformatf("rnd%0d", i), r, f);
    end

    // Reset during WAIT discards the operation; a pending request then proceeds
    @(negedge clk);
    set_req(0, 1'b1, 16'h0F0F, 16'h0101, 5'b10100, 1'b1);
    #1;
    cnt = 0;
    while (!bus.Req0Ready && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    chk("rstw.ready", 32'(bus.Req0Ready), 32'd1);
    @(posedge clk);
    t = alu_calc(5'b10100, 16'h0F0F, 16'h0101, model_flags);
    model_flags = t[3:0];
    @(negedge clk);
    set_req(0, 1'b1, 16'h0005, 16'h0003, 5'b10100, 1'b1);
    #1;
    chk("rstw.exec_rdy", 32'(bus.Req0Ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstw.rspv", 32'(bus.RspValid), 32'd0);
    chk("rstw.safe", {11'd0, bus.AluFunSel, bus.AluA}, {11'd0, 5'b10000, 16'h0000});
    chk("rstw.safe_b", 32'(bus.AluB), 32'd0);
    chk("rstw.safe_wf", 32'(bus.AluWF), 32'd0);
    chk("rstw.rdy_in_rst", 32'(bus.Req0Ready), 32'd0);
    rst = 1'b0;
    rr_last = 1'b1;
    #1;
    chk("rstw.first_idle_grant", 32'(bus.Req0Ready), 32'd1);
    bus.Req0Valid = 1'b0;
    run_op(0, 16'h0005, 16'h0003, 5'b10100, 1'b1, 1, "post_rst", r, f);
    chk("tp.post_rst_res", 32'(r), 32'h0008);

    // Both requesters valid continuously
    do_reset();
    set_req(0, 1'b1, 16'h0001, 16'h0002, 5'b10100, 1'b0);
    set_req(1, 1'b1, 16'h0010, 16'h0020, 5'b10100, 1'b0);
    bus.RspReady = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = ~rr_last;
`else
      exp_id = 1'b0;
`endif
      cnt = 0;
      while (!(bus.Req0Ready || bus.Req1Ready) && cnt < 20) begin
        @(negedge clk); #1; cnt++;
      end
      chk($sformatf("arb%0d.rdy0", k), 32'(bus.Req0Ready), 32'(exp_id == 1'b0));
      chk($sformatf("arb%0d.rdy1", k), 32'(bus.Req1Ready), 32'(exp_id == 1'b1));
      @(posedge clk);
      rr_last = exp_id;
      exp_r = (exp_id == 1'b0) ? 16'h0003 : 16'h0030;
      cnt = 0;
      @(negedge clk); #1;
      while (!bus.RspValid && cnt < 10) begin
        @(negedge clk); #1; cnt++;
      end
      chk($sformatf("arb%0d.rspv", k), 32'(bus.RspValid), 32'd1);
      chk($sformatf("arb%0d.id", k), 32'(bus.RspId), 32'(exp_id));
      chk($sformatf("arb%0d.res", k), 32'(bus.RspResult), 32'(exp_r));
      chk($sformatf("arb%0d.flg", k), 32'(bus.RspFlags), 32'(model_flags));
      @(posedge clk);
      @(negedge clk); #1;
    end
    bus.Req0Valid = 1'b0;
    bus.Req1Valid = 1'b0;
    bus.RspReady  = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_access_arbiter.md
# alu_access_arbiter

Shares one registered ArithmeticLogicUnit instance between two requesters, such as a microcode sequencer and a debug port. The block accepts one operation at a time through valid/ready handshakes, drives the ALU for exactly one flag-writing clock, captures the result and flags, and returns them on a single response channel with backpressure. It sits between the requesters and the ALU ports A, B, FunSel, WF, ALUOut and FlagsOut.

## Interface
Parameters:
- none; widths are fixed to the ALU (operands 16 bits, FunSel 5 bits, flags 4 bits).

Ports:
- Clock  in  1  system clock; the ALU shares it.
- Reset  in  1  synchronous, active-high.
- Req0Valid  in  1  requester 0 has an operation pending.
- Req0Ready  out  1  requester 0 operation accepted this cycle.
- Req0A, Req0B  in  16 each  requester 0 operands.
- Req0FunSel  in  5  requester 0 ALU function code.
- Req0WF  in  1  requester 0 flag-write enable.
- Req1Valid, Req1Ready, Req1A, Req1B, Req1FunSel, Req1WF  same as the requester 0 ports, for requester 1.
- RspValid  out  1  response available.
- RspReady  in  1  consumer takes the response.
- RspId  out  1  index of the requester that issued the operation.
- RspResult  out  16  captured ALUOut.
- RspFlags  out  4  captured FlagsOut, ordered {Z,C,N,O}.
- AluA, AluB  out  16 each  drive the ALU A and B inputs.
- AluFunSel  out  5  drives the ALU FunSel input.
- AluWF  out  1  drives the ALU WF input.
- AluOut  in  16  from the ALU ALUOut output.
- AluFlags  in  4  from the ALU FlagsOut output.

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - Grant at most one requester. ReqNReady = 1 only for the granted requester whose ReqNValid = 1.
  - On the transfer edge, latch the operands, FunSel, WF and the requester id into internal registers, then go to EXEC.
- EXEC:
  - Drive AluA, AluB and AluFunSel from the latched values, and AluWF = latched WF.
  - The ALU executes at the closing edge. Go to WAIT.
- WAIT:
  - Drive the safe pattern.
  - AluOut and AluFlags now hold this operation's result. Register them into RspResult and RspFlags at the closing edge, then go to RESP.
- RESP:
  - RspValid = 1.
  - RspId, RspResult and RspFlags are held stable until RspValid && RspReady. Then go to IDLE.
- Safe pattern, used in every state except EXEC: AluA = 0, AluB = 0, AluFunSel = 5'b10000, AluWF = 0.
  - The ALU clocks every cycle, so AluWF may be 1 only during EXEC. This guarantees carry-dependent functions (ADC, CSL, CSR) and the flags advance exactly once per accepted operation.
- No ReqNReady is asserted outside IDLE. Requests are neither queued nor dropped; they wait.
- Flags pass through unchanged. With WF = 0, RspFlags equals the ALU's prior flags.
- RspResult is not masked by the block. For 8-bit functions (FunSel[4] = 0) the ALU already zeroes bits [15:8].

## Timing
- Accept at edge E0. EXEC in cycle 1, WAIT in cycle 2, RspValid = 1 from cycle 3.
- Minimum spacing is 4 cycles per operation. The next ReqNReady can assert in the cycle after the response handshake.
- Reset values: Req0Ready = Req1Ready = 0, RspValid = 0, RspId = 0, RspResult = 0, RspFlags = 0, ALU outputs at the safe pattern, state IDLE, round-robin pointer favours requester 0.
- Reset mid-operation (any state): the in-flight operation is discarded and no response is issued.
  - If Reset falls in EXEC, the ALU may still have executed. The ALU's internal flags are not restored.
- Simultaneous valids: see Configuration.
- A ReqNValid that drops before Ready is ignored. Ready is combinational from state, pointer and the valids.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A last-grant pointer updates on each accept.
  - When both requesters are valid, the one not granted last wins.
- Not defined: fixed priority. Requester 0 always wins; requester 1 is granted only when Req0Valid = 0.

## Test plan
- Setup: ALU flags start at 0000 after power-up; Reset is held 2 cycles first.
- Req0 FunSel 5'b10100 (A+B), A = 16'h7FFF, B = 16'h0001, WF = 1 -> RspValid in cycle 3 after accept, RspId = 0, RspResult = 16'h8000, RspFlags = 4'b0011.
- Req1 FunSel 5'b00000, A = 16'h12F0, WF = 1 -> RspResult = 16'h00F0, N = 1, RspId = 1; AluWF observed high for exactly one cycle.
- Both valid continuously with ALU_ARB_ROUND_ROBIN_EN -> grants alternate 0,1,0,1. Without the macro -> all grants go to 0.
- RspReady held low for 5 cycles -> RspValid, RspResult and RspFlags stay stable, no ReqNReady, AluWF = 0 throughout.
- Reset asserted during WAIT -> next cycle RspValid = 0, ALU outputs at the safe pattern, and a pending Req0 is granted on the first IDLE cycle after Reset deasserts.
